// File: rtl/pipeline_exec_controller.sv
// Run/step/halt sequencer driving the global pipeline write enable,
// with saturating executed-cycle and hazard-stall counters.
module pipeline_exec_controller #(
  parameter int NB_CNT = 32,
  parameter int NB_CMD = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [NB_CMD-1:0] i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_wb,
  input  logic              i_stall_hazard,
  output logic              o_pipe_enable,
  output logic [1:0]        o_state,
  output logic              o_done,
  output logic [NB_CNT-1:0] o_cycle_count,
  output logic [NB_CNT-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [NB_CMD-1:0] CMD_RUN   = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] CMD_STEP  = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] CMD_PAUSE = NB_CMD'(3);

  state_t            r_state;
  state_t            w_next;
  logic              r_done;
  logic [NB_CNT-1:0] r_cycle;
  logic [NB_CNT-1:0] r_stall;
  logic              w_enable;
  logic              w_ready;
  logic              w_acc;
  logic              w_done_entry;

  assign w_enable = (r_state == S_RUN) | (r_state == S_STEP);
  assign w_ready  = (r_state == S_IDLE) | (r_state == S_RUN);
  assign w_acc    = i_cmd_valid & w_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && i_cmd == CMD_RUN)  w_next = S_RUN;
        if (w_acc && i_cmd == CMD_STEP) w_next = S_STEP;
      end
      S_RUN: begin
        // halt beats a simultaneous pause
        if (i_halt_wb)                        w_next = S_DONE;
        else if (w_acc && i_cmd == CMD_PAUSE) w_next = S_IDLE;
      end
      S_STEP: w_next = i_halt_wb ? S_DONE : S_IDLE;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_done_entry = w_enable & (w_next == S_DONE);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_cycle <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_entry;
      if (w_enable && !(&r_cycle))
        r_cycle <= r_cycle + 1'b1;
      if (w_enable && i_stall_hazard && !(&r_stall))
        r_stall <= r_stall + 1'b1;
    end
  end

  assign o_pipe_enable = w_enable;
  assign o_cmd_ready   = w_ready;
  assign o_state       = r_state;
  assign o_done        = r_done;
  assign o_cycle_count = r_cycle;
  assign o_stall_count = r_stall;

endmodule
